// File: rtl/conv_column_engine.sv
// conv_column_engine: streaming 2-D convolution over a sliding window of image columns.
// Columns arrive over a valid/ready handshake. Once KERNEL_SIZE columns are held, the engine
// emits one output pixel per vertical position (stride 1, no padding), under output backpressure.
// Ports:
//   clk100, in_reset              clock, asynchronous active-low reset
//   i_frame_start                 restarts the frame; latches i_kernel / i_shift
//   i_kernel, i_shift             signed KxK coefficients (row-major, (0,0) in MSBs), right shift
//   i_col, i_col_valid, o_col_ready   column input (row 0 in MSBs)
//   o_pixel, o_pix_valid, i_pix_ready output pixel stream
//   o_row, o_last_row             row index of o_pixel, last-row flag
module conv_column_engine #(
    parameter int unsigned IMG_HEIGHT  = 480,
    parameter int unsigned IMG_NB      = 8,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned KERNEL_NB   = 8,
    parameter int unsigned OUT_NB      = 8
) (
    input  logic                                         clk100,
    input  logic                                         in_reset,
    input  logic                                         i_frame_start,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_NB-1:0] i_kernel,
    input  logic [3:0]                                   i_shift,
    input  logic [IMG_HEIGHT*IMG_NB-1:0]                 i_col,
    input  logic                                         i_col_valid,
    output logic                                         o_col_ready,
    output logic [OUT_NB-1:0]                            o_pixel,
    output logic                                         o_pix_valid,
    input  logic                                         i_pix_ready,
    output logic [15:0]                                  o_row,
    output logic                                         o_last_row
);

    localparam int unsigned KW       = KERNEL_SIZE * KERNEL_SIZE * KERNEL_NB;
    localparam int unsigned COLW     = IMG_HEIGHT * IMG_NB;
    localparam int unsigned ACC_NB   = IMG_NB + KERNEL_NB + $clog2(KERNEL_SIZE * KERNEL_SIZE) + 1;
    localparam int unsigned IDX_NB   = $clog2(IMG_HEIGHT);
    localparam int unsigned CNT_NB   = $clog2(KERNEL_SIZE + 1);
    localparam int unsigned LAST_ROW = IMG_HEIGHT - KERNEL_SIZE;
    localparam logic signed [ACC_NB-1:0] SAT_MAX = ACC_NB'((2 ** OUT_NB) - 1);

    typedef enum logic {
        S_FILL    = 1'b0,
        S_COMPUTE = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_accept;
    logic                     w_issue;
    logic                     w_row_last;
    logic                     w_fill_done;

    logic                     r_armed;
    logic [CNT_NB-1:0]        r_col_cnt;
    logic [IDX_NB-1:0]        r_row;
    logic [KW-1:0]            r_kernel;
    logic [3:0]               r_shift;
    logic [OUT_NB-1:0]        r_pixel;
    logic                     r_pix_valid;
    logic [15:0]              r_row_out;
    logic                     r_last_row;

    // Window storage: index 0 is the oldest column.
    logic [IMG_NB-1:0]        r_win [KERNEL_SIZE][IMG_HEIGHT];

    logic [IMG_NB-1:0]        w_tap;
    logic signed [ACC_NB-1:0] w_pix_s;
    logic signed [ACC_NB-1:0] w_coef_s;
    logic signed [ACC_NB-1:0] w_acc;
    logic signed [ACC_NB-1:0] w_res;
    logic [OUT_NB-1:0]        w_sat;

    assign o_col_ready = (r_state == S_FILL);
    assign o_pixel     = r_pixel;
    assign o_pix_valid = r_pix_valid;
    assign o_row       = r_row_out;
    assign o_last_row  = r_last_row;

    assign w_row_last  = (r_row == IDX_NB'(LAST_ROW));
    assign w_fill_done = (r_col_cnt == CNT_NB'(KERNEL_SIZE - 1));

    // Next-state and handshake decisions; frame start overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_FILL: begin
                // Columns offered before the first frame start are dropped.
                w_accept = i_col_valid & r_armed;
                if (w_accept && w_fill_done) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                w_issue = !r_pix_valid | i_pix_ready;
                if (w_issue && w_row_last) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
        if (i_frame_start) begin
            w_state_nxt = S_FILL;
            w_accept    = 1'b0;
            w_issue     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk100 or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Window shift; data needs no reset since it is only read after a full refill.
    always_ff @(posedge clk100) begin
        if (w_accept) begin
            for (int c = 0; c < int'(KERNEL_SIZE) - 1; c++) begin
                r_win[c] <= r_win[c+1];
            end
            for (int h = 0; h < int'(IMG_HEIGHT); h++) begin
                r_win[KERNEL_SIZE-1][h] <= i_col[COLW-1-IMG_NB*h -: IMG_NB];
            end
        end
    end

    // Multiply-accumulate over the window at the current row, then shift and clamp.
    always_comb begin
        w_tap    = '0;
        w_pix_s  = '0;
        w_coef_s = '0;
        w_acc    = '0;
        for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
            for (int c = 0; c < int'(KERNEL_SIZE); c++) begin
                w_tap    = r_win[c][r_row + IDX_NB'(r)];
                w_pix_s  = ACC_NB'($signed({1'b0, w_tap}));
                w_coef_s = ACC_NB'($signed(r_kernel[KW-1-KERNEL_NB*(r*KERNEL_SIZE+c) -: KERNEL_NB]));
                w_acc    = w_acc + w_pix_s * w_coef_s;
            end
        end
        w_res = w_acc >>> r_shift;
        if (w_res[ACC_NB-1]) begin
            w_sat = '0;
        end else if (w_res > SAT_MAX) begin
            w_sat = '1;
        end else begin
            w_sat = w_res[OUT_NB-1:0];
        end
    end

    // Counters, latched configuration and registered output stage.
    always_ff @(posedge clk100 or negedge in_reset) begin
        if (!in_reset) begin
            r_armed     <= 1'b0;
            r_col_cnt   <= '0;
            r_row       <= '0;
            r_kernel    <= '0;
            r_shift     <= '0;
            r_pixel     <= '0;
            r_pix_valid <= 1'b0;
            r_row_out   <= '0;
            r_last_row  <= 1'b0;
        end else if (i_frame_start) begin
            r_armed     <= 1'b1;
            r_kernel    <= i_kernel;
            r_shift     <= i_shift;
            r_col_cnt   <= '0;
            r_row       <= '0;
            r_pix_valid <= 1'b0;
            r_last_row  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col_cnt <= r_col_cnt + CNT_NB'(1);
            end
            if (w_issue) begin
                r_pixel     <= w_sat;
                r_row_out   <= 16'(r_row);
                r_last_row  <= w_row_last;
                r_pix_valid <= 1'b1;
                if (w_row_last) begin
                    // Slide by one column: the next accepted column completes a new window.
                    r_row     <= '0;
                    r_col_cnt <= CNT_NB'(KERNEL_SIZE - 1);
                end else begin
                    r_row <= r_row + IDX_NB'(1);
                end
            end else if (i_pix_ready) begin
                r_pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_column_engine.sv
// Directed bench for conv_column_engine: an 8-row / 3x3 instance for the main scenarios and a
// 16-row / 5x5 instance for the larger-kernel saturation case.
module tb_conv_column_engine;

    localparam int unsigned H_A  = 8;
    localparam int unsigned K_A  = 3;
    localparam int unsigned KW_A = K_A * K_A * 8;
    localparam int unsigned CW_A = H_A * 8;
    localparam int unsigned H_B  = 16;
    localparam int unsigned K_B  = 5;
    localparam int unsigned KW_B = K_B * K_B * 8;
    localparam int unsigned CW_B = H_B * 8;

    logic            clk100 = 1'b0;
    logic            in_reset;

    logic            i_frame_start;
    logic [KW_A-1:0] i_kernel;
    logic [3:0]      i_shift;
    logic [CW_A-1:0] i_col;
    logic            i_col_valid;
    logic            o_col_ready;
    logic [7:0]      o_pixel;
    logic            o_pix_valid;
    logic            i_pix_ready;
    logic [15:0]     o_row;
    logic            o_last_row;

    logic            b_frame_start;
    logic [KW_B-1:0] b_kernel;
    logic [3:0]      b_shift;
    logic [CW_B-1:0] b_col;
    logic            b_col_valid;
    logic            b_col_ready;
    logic [7:0]      b_pixel;
    logic            b_pix_valid;
    logic            b_pix_ready;
    logic [15:0]     b_row;
    logic            b_last_row;

    always #5 clk100 = ~clk100;

    conv_column_engine #(
        .IMG_HEIGHT(H_A), .IMG_NB(8), .KERNEL_SIZE(K_A), .KERNEL_NB(8), .OUT_NB(8)
    ) dut_a (
        .clk100(clk100), .in_reset(in_reset), .i_frame_start(i_frame_start),
        .i_kernel(i_kernel), .i_shift(i_shift), .i_col(i_col), .i_col_valid(i_col_valid),
        .o_col_ready(o_col_ready), .o_pixel(o_pixel), .o_pix_valid(o_pix_valid),
        .i_pix_ready(i_pix_ready), .o_row(o_row), .o_last_row(o_last_row)
    );

    conv_column_engine #(
        .IMG_HEIGHT(H_B), .IMG_NB(8), .KERNEL_SIZE(K_B), .KERNEL_NB(8), .OUT_NB(8)
    ) dut_b (
        .clk100(clk100), .in_reset(in_reset), .i_frame_start(b_frame_start),
        .i_kernel(b_kernel), .i_shift(b_shift), .i_col(b_col), .i_col_valid(b_col_valid),
        .o_col_ready(b_col_ready), .o_pixel(b_pixel), .o_pix_valid(b_pix_valid),
        .i_pix_ready(b_pix_ready), .o_row(b_row), .o_last_row(b_last_row)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int pat_mode = 0;
    logic [3:0] pat = 4'b1001;

    logic        prv_v, prv_r;
    logic [7:0]  prv_p;
    logic [15:0] prv_row;

    int q_pix[$];
    int q_row[$];
    int q_last[$];
    int q_t[$];
    int bq_pix[$];
    int bq_row[$];
    int bq_last[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge, choose i_pix_ready, log transfers, check held outputs.
    task automatic cyc();
        @(negedge clk100);
        if (pat_mode == 1 && prv_v && !prv_r) begin
            check("hold_valid", 32'(o_pix_valid), 32'd1);
            check("hold_pixel", 32'(o_pixel), 32'(prv_p));
            check("hold_row", 32'(o_row), 32'(prv_row));
        end
        i_pix_ready = (pat_mode == 0) ? 1'b1 : pat[2'(cyc_n)];
        if (o_pix_valid && i_pix_ready) begin
            q_pix.push_back(int'(o_pixel));
            q_row.push_back(int'(o_row));
            q_last.push_back(int'(o_last_row));
            q_t.push_back(cyc_n);
        end
        prv_v   = o_pix_valid;
        prv_r   = i_pix_ready;
        prv_p   = o_pixel;
        prv_row = o_row;
        cyc_n++;
    endtask

    task automatic clear_q();
        q_pix.delete();
        q_row.delete();
        q_last.delete();
        q_t.delete();
    endtask

    task automatic send_col(input logic [CW_A-1:0] col);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            cyc();
            i_col       = col;
            i_col_valid = 1'b1;
            if (o_col_ready) done = 1'b1;
        end
        if (!done) check("col_accept_timeout", 32'd0, 32'd1);
        cyc();
        i_col_valid = 1'b0;
    endtask

    task automatic frame(input logic [KW_A-1:0] k, input logic [3:0] sh);
        cyc();
        i_frame_start = 1'b1;
        i_kernel      = k;
        i_shift       = sh;
        cyc();
        i_frame_start = 1'b0;
    endtask

    task automatic drain(input int n, input int maxc);
        for (int k = 0; k < maxc && q_pix.size() < n; k++) cyc();
        check("drain_count", 32'(q_pix.size()), 32'(n));
    endtask

    function automatic logic [CW_A-1:0] col_a(input int base, input int step);
        logic [CW_A-1:0] c;
        c = '0;
        for (int h = 0; h < int'(H_A); h++) c[CW_A-1-8*h -: 8] = 8'(base + step * h);
        return c;
    endfunction

    function automatic logic [KW_A-1:0] kern_all(input logic [7:0] v);
        logic [KW_A-1:0] k;
        for (int i = 0; i < int'(K_A * K_A); i++) k[KW_A-1-8*i -: 8] = v;
        return k;
    endfunction

    // Fresh frame, three uniform columns, one window of six pixels all equal to exp.
    task automatic win_uniform(input string tag, input logic [7:0] coef, input logic [3:0] sh,
                               input int pix, input int exp);
        frame(kern_all(coef), sh);
        clear_q();
        for (int i = 0; i < 3; i++) send_col(col_a(pix, 0));
        drain(6, 60);
        for (int i = 0; i < q_pix.size(); i++) check($sformatf("%s_pix%0d", tag, i), 32'(q_pix[i]), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KW_A-1:0] kc;
        bit hit;
        in_reset = 1'b0;
        i_frame_start = 1'b0; i_kernel = '0; i_shift = '0; i_col = '0; i_col_valid = 1'b0;
        i_pix_ready = 1'b1;
        b_frame_start = 1'b0; b_kernel = '0; b_shift = '0; b_col = '0; b_col_valid = 1'b0;
        b_pix_ready = 1'b1;
        prv_v = 1'b0; prv_r = 1'b1; prv_p = '0; prv_row = '0;

        // Reset state
        #1;
        check("rst_pix_valid", 32'(o_pix_valid), 32'd0);
        check("rst_pixel", 32'(o_pixel), 32'd0);
        check("rst_row", 32'(o_row), 32'd0);
        check("rst_last_row", 32'(o_last_row), 32'd0);
        cyc();
        in_reset = 1'b1;
        cyc();
        check("rst_col_ready", 32'(o_col_ready), 32'd1);

        // 1: ones kernel, ones image, two windows with a single-cycle refill
        frame(kern_all(8'd1), 4'd0);
        clear_q();
        for (int i = 0; i < 4; i++) send_col(col_a(1, 0));
        drain(12, 80);
        for (int i = 0; i < q_pix.size(); i++) begin
            check($sformatf("t1_pix%0d", i), 32'(q_pix[i]), 32'd9);
            check($sformatf("t1_row%0d", i), 32'(q_row[i]), 32'(i % 6));
            check($sformatf("t1_last%0d", i), 32'(q_last[i]), 32'((i % 6) == 5));
        end
        if (q_t.size() >= 7) check("t1_refill_gap", 32'(q_t[6] - q_t[5]), 32'd2);

        // 2: output backpressure 1,0,0,1
        frame(kern_all(8'd1), 4'd0);
        clear_q();
        prv_v = 1'b0;
        pat_mode = 1;
        for (int i = 0; i < 3; i++) send_col(col_a(1, 0));
        drain(6, 80);
        repeat (20) cyc();
        check("t2_count_after_idle", 32'(q_pix.size()), 32'd6);
        for (int i = 0; i < q_pix.size(); i++) begin
            check($sformatf("t2_pix%0d", i), 32'(q_pix[i]), 32'd9);
            check($sformatf("t2_row%0d", i), 32'(q_row[i]), 32'(i));
        end
        pat_mode = 0;

        // 3: saturation and shift with 255 pixels; 9*255*127 = 291465
        win_uniform("t3_neg", 8'hFF, 4'd0, 255, 0);
        win_uniform("t3_sat", 8'h7F, 4'd0, 255, 255);
        win_uniform("t3_sh10", 8'h7F, 4'd10, 255, 255);
        win_uniform("t3_sh12", 8'h7F, 4'd12, 255, 71);
        win_uniform("t3_sh15", 8'h7F, 4'd15, 255, 8);

        // 4: frame start during COMPUTE at row 3, new centre-only kernel
        frame(kern_all(8'd1), 4'd0);
        clear_q();
        for (int i = 0; i < 3; i++) send_col(col_a(1, 0));
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            cyc();
            if (o_pix_valid && o_row == 16'd3) hit = 1'b1;
        end
        check("t4_reach_row3", 32'(hit), 32'd1);
        kc = '0;
        kc[KW_A-1-8*4 -: 8] = 8'd2;
        i_frame_start = 1'b1;
        i_kernel = kc;
        i_shift = 4'd0;
        cyc();
        i_frame_start = 1'b0;
        check("t4_valid_drop", 32'(o_pix_valid), 32'd0);
        check("t4_last_clear", 32'(o_last_row), 32'd0);
        clear_q();
        send_col(col_a(1, 1));
        send_col(col_a(11, 1));
        repeat (10) cyc();
        check("t4_no_pix_2cols", 32'(q_pix.size()), 32'd0);
        send_col(col_a(21, 1));
        drain(6, 60);
        for (int i = 0; i < q_pix.size(); i++) begin
            check($sformatf("t4_pix%0d", i), 32'(q_pix[i]), 32'(2 * i + 24));
            check($sformatf("t4_row%0d", i), 32'(q_row[i]), 32'(i));
        end

        // 5: asynchronous reset mid-window
        frame(kern_all(8'd1), 4'd0);
        clear_q();
        for (int i = 0; i < 3; i++) send_col(col_a(1, 0));
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            cyc();
            if (o_pix_valid) hit = 1'b1;
        end
        check("t5_pix_before_rst", 32'(hit), 32'd1);
        #2 in_reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_pix_valid), 32'd0);
        check("t5_rst_pixel", 32'(o_pixel), 32'd0);
        check("t5_rst_row", 32'(o_row), 32'd0);
        check("t5_rst_last", 32'(o_last_row), 32'd0);
        cyc();
        in_reset = 1'b1;
        cyc();
        check("t5_col_ready", 32'(o_col_ready), 32'd1);
        clear_q();
        for (int i = 0; i < 3; i++) send_col(col_a(1, 0));
        repeat (20) cyc();
        check("t5_no_pix_unarmed", 32'(q_pix.size()), 32'd0);
        frame(kern_all(8'd1), 4'd0);
        clear_q();
        for (int i = 0; i < 3; i++) send_col(col_a(1, 0));
        drain(6, 60);
        if (q_pix.size() == 6) begin
            check("t5_pix0", 32'(q_pix[0]), 32'd9);
            check("t5_row5", 32'(q_row[5]), 32'd5);
            check("t5_last5", 32'(q_last[5]), 32'd1);
        end

        // 6: 5x5 kernel, 16 rows, pixel = row index; row n -> 5*(5n+10), clamped to 255
        for (int i = 0; i < int'(K_B * K_B); i++) b_kernel[KW_B-1-8*i -: 8] = 8'd1;
        for (int h = 0; h < int'(H_B); h++) b_col[CW_B-1-8*h -: 8] = 8'(h);
        @(negedge clk100);
        b_frame_start = 1'b1;
        @(negedge clk100);
        b_frame_start = 1'b0;
        b_col_valid = 1'b1;
        repeat (5) @(negedge clk100);
        b_col_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (b_pix_valid) begin
                bq_pix.push_back(int'(b_pixel));
                bq_row.push_back(int'(b_row));
                bq_last.push_back(int'(b_last_row));
            end
            @(negedge clk100);
        end
        check("t6_count", 32'(bq_pix.size()), 32'd12);
        for (int i = 0; i < bq_pix.size(); i++) begin
            check($sformatf("t6_pix%0d", i), 32'(bq_pix[i]), 32'((i >= 9) ? 255 : 25 * i + 50));
            check($sformatf("t6_row%0d", i), 32'(bq_row[i]), 32'(i));
            check($sformatf("t6_last%0d", i), 32'(bq_last[i]), 32'(i == 11));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
